// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with a load/store front end (B/H/W, sign/zero extend, error checks).
// Latency: rsp_valid rises LATENCY+1 cycles after the accept cycle; one request in flight at a time.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready. DMEM_CLEAR_EN adds a zeroing sweep after reset.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;
    localparam logic       LAT_ZERO = (LATENCY == 0);
    localparam logic [3:0] LAT_M1   = LAT_ZERO ? 4'd0 : 4'(LATENCY - 1);
`ifdef DMEM_CLEAR_EN
    localparam logic [1:0] S_RST = S_CLEAR;
`else
    localparam logic [1:0] S_RST = S_IDLE;
`endif

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_write;
    logic [2:0]        lat_funct3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       mem [DEPTH_WORDS];
`ifdef DMEM_CLEAR_EN
    logic [IDX_W-1:0]  clr_idx;
`endif

    logic              accept;
    logic              commit;
    logic              acc_write;
    logic [2:0]        acc_funct3;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [1:0]        lane;
    logic [IDX_W-1:0]  idx;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wdat;
    logic [31:0]       rd_word;
    logic [15:0]       sh;
    logic [31:0]       ext;
    logic              we;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && (state == S_IDLE);
    assign commit    = ((state == S_WAIT) && (cnt == 4'd0)) || (accept && LAT_ZERO);

    // With zero wait states the access commits on the accept edge, so decode straight from the inputs.
    assign acc_write  = (state == S_IDLE) ? req_write  : lat_write;
    assign acc_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
    assign acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
    assign acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
    assign lane       = acc_addr[1:0];
    assign idx        = acc_addr[IDX_W+1:2];

    always_comb begin
        err  = 1'b0;
        be   = 4'b0000;
        wdat = acc_wdata;
        case (acc_funct3)
            3'b000: begin
                be   = 4'b0001 << lane;
                wdat = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                be   = 4'b0011 << lane;
                wdat = {2{acc_wdata[15:0]}};
                err  = lane[0];
            end
            3'b010: begin
                be  = 4'b1111;
                err = (lane != 2'b00);
            end
            3'b100:  err = acc_write;
            3'b101:  err = acc_write | lane[0];
            default: err = 1'b1;
        endcase
        if ((acc_addr >> (IDX_W + 2)) != '0) begin
            err = 1'b1;
        end
    end

    assign rd_word = mem[idx];
    assign sh      = 16'(rd_word >> {lane, 3'b000});

    always_comb begin
        case (acc_funct3)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  ext = {24'd0, sh[7:0]};
            3'b101:  ext = {16'd0, sh[15:0]};
            default: ext = rd_word;
        endcase
    end

    assign we = commit && acc_write && !err;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
`ifdef DMEM_CLEAR_EN
        else if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_RST;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef DMEM_CLEAR_EN
            clr_idx    <= '0;
`endif
        end else begin
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || acc_write) ? 32'd0 : ext;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_funct3 <= req_funct3;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        if (LAT_ZERO) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
`ifdef DMEM_CLEAR_EN
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed vector bench for dmem_lsu (LATENCY=1, DEPTH_WORDS=64) plus back-pressure and mid-flight reset sequences.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_WORDS(64), .ADDR_W(32), .LATENCY(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 31;
    vec_t vt [NV];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic hold,
                          output logic [31:0] rd, output logic er, output int lat);
        int g;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        lat = 1;
        #1 req_valid = 1'b0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!hold) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        vt[0]  = '{1'b1, 3'b010, 32'h00,  32'h11111111, 32'h0,        1'b0};
        vt[1]  = '{1'b1, 3'b010, 32'h14,  32'h01234567, 32'h0,        1'b0};
        vt[2]  = '{1'b1, 3'b010, 32'hFC,  32'hCAFEF00D, 32'h0,        1'b0};
        vt[3]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[4]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[5]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        vt[6]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        vt[7]  = '{1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
        vt[8]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 1'b0};
        vt[9]  = '{1'b1, 3'b000, 32'h11,  32'h00000055, 32'h0,        1'b0};
        vt[10] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0};
        vt[11] = '{1'b0, 3'b010, 32'h14,  32'h0,        32'h01234567, 1'b0};
        vt[12] = '{1'b0, 3'b010, 32'h00,  32'h0,        32'h11111111, 1'b0};
        vt[13] = '{1'b0, 3'b000, 32'h11,  32'h0,        32'h00000055, 1'b0};
        vt[14] = '{1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0};
        vt[15] = '{1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1};
        vt[16] = '{1'b1, 3'b001, 32'h11,  32'h0000ABCD, 32'h0,        1'b1};
        vt[17] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 1'b0};
        vt[18] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1};
        vt[19] = '{1'b0, 3'b111, 32'h00,  32'h0,        32'h0,        1'b1};
        vt[20] = '{1'b1, 3'b010, 32'h100, 32'h22222222, 32'h0,        1'b1};
        vt[21] = '{1'b0, 3'b010, 32'h00,  32'h0,        32'h11111111, 1'b0};
        vt[22] = '{1'b1, 3'b100, 32'h14,  32'h000000FF, 32'h0,        1'b1};
        vt[23] = '{1'b0, 3'b010, 32'h14,  32'h0,        32'h01234567, 1'b0};
        vt[24] = '{1'b0, 3'b001, 32'h16,  32'h0,        32'h00000123, 1'b0};
        vt[25] = '{1'b0, 3'b010, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0};
        vt[26] = '{1'b1, 3'b001, 32'h16,  32'h00008899, 32'h0,        1'b0};
        vt[27] = '{1'b0, 3'b010, 32'h14,  32'h0,        32'h88994567, 1'b0};
        vt[28] = '{1'b0, 3'b001, 32'h16,  32'h0,        32'hFFFF8899, 1'b0};
        vt[29] = '{1'b0, 3'b011, 32'h00,  32'h0,        32'h0,        1'b1};
        vt[30] = '{1'b0, 3'b101, 32'h11,  32'h0,        32'h0,        1'b1};

        #12;
`ifdef DMEM_CLEAR_EN
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_busy",      32'(busy),      32'd1);
`else
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_busy",      32'(busy),      32'd0);
`endif
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata,      32'd0);
        chk("reset_rsp_err",   32'(rsp_err),   32'd0);

        @(negedge clk);
        reset = 1'b1;
`ifdef DMEM_CLEAR_EN
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'd64);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, rd, er, lat);
        chk("clear_word0", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h80, 32'h0, 1'b0, rd, er, lat);
        chk("clear_word32", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'hFC, 32'h0, 1'b0, rd, er, lat);
        chk("clear_word63", rd, 32'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            do_req(vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, 1'b0, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Response held under back-pressure.
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, er, lat);
        chk("hold_first_rdata", rd, 32'hDEAD55EF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d_rsp_rdata", c), rsp_rdata, 32'hDEAD55EF);
            chk($sformatf("hold%0d_req_ready", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_busy",      32'(busy),      32'd0);

        // Reset pulse while a store waits: the store must be dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        req_wdata  = 32'hBAD0BAD0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        chk("midreset_busy",      32'(busy),      32'd0);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        #2 reset = 1'b1;
`ifdef DMEM_CLEAR_EN
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reclear_cycles", 32'(n), 32'd64);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, rd, er, lat);
        chk("dropped_store_word", rd, 32'd0);
`else
        repeat (3) @(posedge clk);
        #1;
        chk("dropped_store_no_rsp", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, rd, er, lat);
        chk("dropped_store_word", rd, 32'h88994567);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
